sad_pool_ctrl: RTL and testbench
================================

# sad_pool_ctrl

Sequencer that shares one combinational `AbsoluteDeviation` unit across a streamed pooling window held in two synchronous-read BRAM ports. On `start` it walks `len` element pairs (A[base_a+i], B[base_b+i]), feeds each pair to the deviation unit, and produces the sum of absolute deviations, the maximum deviation and its index. It sits between the pooling BRAM and the downstream pooling/compare logic. It owns the BRAM read enables and addresses while busy.

## Interface
- `ADDR_W`, 10, BRAM address width
- `LEN_W`, 8, width of window length; max window 2^LEN_W-1 = 255
- `clk` in 1, single clock, all state on rising edge
- `rst_n` in 1, asynchronous active-low reset
- `start` in 1, pulse; sampled only in IDLE
- `base_a` in ADDR_W, window A start address, captured at start
- `base_b` in ADDR_W, window B start address, captured at start
- `len` in LEN_W, number of pairs, captured at start
- `bram_en` out 1, read enable to both BRAM ports
- `addr_a` out ADDR_W, BRAM port A address
- `addr_b` out ADDR_W, BRAM port B address
- `rdata_a` in 8, port A read data, valid one cycle after address/enable
- `rdata_b` in 8, port B read data, same latency
- `ad_x1` out 8, to deviation unit x1 (= rdata_a passthrough)
- `ad_x2` out 8, to deviation unit x2 (= rdata_b passthrough)
- `ad_in` in 8, deviation unit result |x1-x2|
- `busy` out 1, high from start acceptance until done cycle inclusive
- `done` out 1, one-cycle pulse, results valid
- `sad` out 16, sum of absolute deviations
- `max_dev` out 8, largest deviation in window
- `max_idx` out LEN_W, index i of first occurrence of max_dev

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: `start`=1 with `len`>0 -> capture base_a/base_b/len, clear accumulators, idx=0, go READ. `start` with `len`=0 -> go DONE directly, sad=0, max_dev=0, max_idx=0.
- READ: bram_en=1, addr_a=base_a+idx, addr_b=base_b+idx (mod 2^ADDR_W, wrap-around permitted). idx increments each cycle; after issuing idx=len-1 go DRAIN.
- Data-valid flag is bram_en delayed one cycle. On each edge with data-valid: sad += ad_in (zero-extended); if ad_in > max_dev then max_dev=ad_in, max_idx=element index. Strict compare, so ties keep the earlier index. The first element always loads max (max cleared to 0, index 0).
- DRAIN: bram_en=0, consume last data word, go DONE.
- DONE: done=1 for one cycle, go IDLE. sad/max_dev/max_idx hold until the next accepted start clears them.
- sad cannot overflow: 255×255 = 65025 < 2^16.
- `start` while not IDLE is ignored (no queueing). Inputs base/len are don't-care after capture.
- ad_x1/ad_x2 are combinational from rdata; ad_in is consumed in the same cycle. The external unit must be purely combinational.

## Timing
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, bram_en=0, addr_a=0, addr_b=0, sad=0, max_dev=0, max_idx=0, idx=0, data-valid=0.
- Reset mid-operation aborts immediately. No done is issued and results are cleared.
- Start sampled at edge T, len=N>0:
  - READ occupies cycles T..T+N-1, address i is presented in cycle T+i.
  - rdata for element i arrives in cycle T+i+1 and is accumulated at edge T+i+2.
  - DRAIN is cycle T+N, DONE is cycle T+N+1: done=1 with final results.
  - busy=1 in cycles T..T+N+1.
- len=0: DONE in cycle T, busy=1 for that single cycle.
- Back-to-back: start may be asserted in the DONE cycle only if sampled after returning to IDLE. The earliest new acceptance is the edge ending the DONE cycle plus one, i.e. minimum 1 idle cycle between windows.
- Throughput: one pair per clock, N+2 cycles per window including overhead.

## Test plan
- A=[10,20,30,40], B=[12,15,30,50], base 0/0x100, len=4 -> done at T+5, sad=17, max_dev=10, max_idx=3, addresses 0..3 and 0x100..0x103.
- len=0 -> done in the start-accepted cycle, sad=0, max_dev=0, no bram_en.
- len=255, A all 255, B all 0 -> sad=65025, max_dev=255, max_idx=0, done at T+256.
- base_a=0x3FE, len=4 -> addr_a sequence 0x3FE,0x3FF,0x000,0x001. Tie case: deviations [5,9,9,2] -> max_idx=1.
- start re-asserted during READ -> ignored, results match the first window. rst_n low at T+2 of len=8 -> all outputs 0 immediately, no done pulse, next start runs cleanly.

Source files
------------

// File: rtl/sad_pool_ctrl_if.sv
// rtl/sad_pool_ctrl_if.sv - BRAM read ports and absolute-deviation unit hookup for sad_pool_ctrl
interface sad_pool_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              bram_en;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [7:0]        rdata_a;
    logic [7:0]        rdata_b;
    logic [7:0]        ad_x1;
    logic [7:0]        ad_x2;
    logic [7:0]        ad_in;

    modport master (
        output bram_en, addr_a, addr_b, ad_x1, ad_x2,
        input  rdata_a, rdata_b, ad_in
    );

    modport slave (
        input  bram_en, addr_a, addr_b, ad_x1, ad_x2,
        output rdata_a, rdata_b, ad_in
    );
endinterface

// File: rtl/sad_pool_ctrl.sv
// rtl/sad_pool_ctrl.sv - streams a BRAM window pair through a shared deviation unit, returns SAD and max
module sad_pool_ctrl #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [LEN_W-1:0]  len,
    sad_pool_ctrl_if.master   mem,
    output logic              busy,
    output logic              done,
    output logic [15:0]       sad,
    output logic [7:0]        max_dev,
    output logic [LEN_W-1:0]  max_idx
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] base_a_r;
    logic [ADDR_W-1:0] base_b_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  idx;
    logic [LEN_W-1:0]  didx;
    logic              dv;
    logic              accept;

    assign accept    = (state == IDLE) && start;
    assign mem.ad_x1 = mem.rdata_a;
    assign mem.ad_x2 = mem.rdata_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len == '0) ? DONE : READ;
            READ:    if (idx == len_r - LEN_W'(1)) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        done        = (state == DONE);
        mem.bram_en = (state == READ);
        mem.addr_a  = base_a_r + ADDR_W'(idx);
        mem.addr_b  = base_b_r + ADDR_W'(idx);
    end

    // dv/didx track the element whose read data is on rdata this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_a_r <= '0;
            base_b_r <= '0;
            len_r    <= '0;
            idx      <= '0;
            didx     <= '0;
            dv       <= 1'b0;
            sad      <= '0;
            max_dev  <= '0;
            max_idx  <= '0;
        end else begin
            dv   <= mem.bram_en;
            didx <= idx;
            if (accept) begin
                base_a_r <= base_a;
                base_b_r <= base_b;
                len_r    <= len;
                idx      <= '0;
                sad      <= '0;
                max_dev  <= '0;
                max_idx  <= '0;
            end else begin
                if (state == READ) idx <= idx + LEN_W'(1);
                if (dv) begin
                    sad <= sad + 16'(mem.ad_in);
                    // strict compare keeps the earliest index on ties
                    if (mem.ad_in > max_dev) begin
                        max_dev <= mem.ad_in;
                        max_idx <= didx;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sad_pool_ctrl.sv
// tb/tb_sad_pool_ctrl.sv - directed self-checking bench for sad_pool_ctrl
module tb_sad_pool_ctrl;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  base_a;
    logic [9:0]  base_b;
    logic [7:0]  len;
    logic        busy;
    logic        done;
    logic [15:0] sad;
    logic [7:0]  max_dev;
    logic [7:0]  max_idx;

    sad_pool_ctrl_if #(.ADDR_W(10)) bus ();

    sad_pool_ctrl #(.ADDR_W(10), .LEN_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .base_a  (base_a),
        .base_b  (base_b),
        .len     (len),
        .mem     (bus),
        .busy    (busy),
        .done    (done),
        .sad     (sad),
        .max_dev (max_dev),
        .max_idx (max_idx)
    );

    logic [7:0] mem_a [0:1023];
    logic [7:0] mem_b [0:1023];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rdata_a <= '0;
            bus.rdata_b <= '0;
        end else if (bus.bram_en) begin
            bus.rdata_a <= mem_a[bus.addr_a];
            bus.rdata_b <= mem_b[bus.addr_b];
        end
    end

    assign bus.ad_in = (bus.ad_x1 > bus.ad_x2) ? bus.ad_x1 - bus.ad_x2 : bus.ad_x2 - bus.ad_x1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cyc;
    int en_cnt;
    int addr_err;
    int busy_cnt;
    logic [9:0] log_a [0:299];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    task automatic run_window(input logic [9:0] ba, input logic [9:0] bb, input logic [7:0] n,
                              input bit retrig);
        @(negedge clk);
        start  = 1'b1;
        base_a = ba;
        base_b = bb;
        len    = n;
        @(posedge clk);
        #1;
        start    = 1'b0;
        base_a   = '0;
        base_b   = '0;
        len      = '0;
        done_cyc = -1;
        en_cnt   = 0;
        addr_err = 0;
        busy_cnt = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (busy) busy_cnt++;
            if (bus.bram_en) begin
                if (cyc < 300) log_a[cyc] = bus.addr_a;
                if (bus.addr_a !== ba + 10'(cyc) || bus.addr_b !== bb + 10'(cyc)) addr_err++;
                en_cnt++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (retrig && cyc == 1) begin
                start  = 1'b1;
                base_a = 10'h050;
                len    = 8'd2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic load_t1;
        mem_a[0] = 8'd10; mem_a[1] = 8'd20; mem_a[2] = 8'd30; mem_a[3] = 8'd40;
        mem_b[10'h100] = 8'd12; mem_b[10'h101] = 8'd15;
        mem_b[10'h102] = 8'd30; mem_b[10'h103] = 8'd50;
    endtask

    initial begin
        int seen_done;
        rst_n  = 1'b0;
        start  = 1'b0;
        base_a = '0;
        base_b = '0;
        len    = '0;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bram_en", bus.bram_en, 0);
        check("rst_addr_a", bus.addr_a, 0);
        check("rst_addr_b", bus.addr_b, 0);
        check("rst_sad", sad, 0);
        check("rst_max", {max_dev, max_idx}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic 4-element window: devs 2,5,0,10
        load_t1();
        run_window(10'h000, 10'h100, 8'd4, 1'b0);
        check("t1_done_cyc", done_cyc, 5);
        check("t1_sad", sad, 17);
        check("t1_max_dev", max_dev, 10);
        check("t1_max_idx", max_idx, 3);
        check("t1_en_cnt", en_cnt, 4);
        check("t1_addr_err", addr_err, 0);
        check("t1_busy_cycles", busy_cnt, 6);
        @(posedge clk);
        #1;
        check("t1_done_pulse", done, 0);
        check("t1_busy_after", busy, 0);
        check("t1_sad_hold", sad, 17);

        // zero-length window
        @(negedge clk);
        run_window(10'h010, 10'h020, 8'd0, 1'b0);
        check("t2_done_cyc", done_cyc, 0);
        check("t2_sad", sad, 0);
        check("t2_max", {max_dev, max_idx}, 0);
        check("t2_en_cnt", en_cnt, 0);
        check("t2_busy_cycles", busy_cnt, 1);

        // full-length window at maximum deviation
        for (int i = 0; i < 255; i++) begin
            mem_a[i] = 8'd255;
            mem_b[10'h200 + i] = 8'd0;
        end
        @(negedge clk);
        run_window(10'h000, 10'h200, 8'd255, 1'b0);
        check("t3_done_cyc", done_cyc, 256);
        check("t3_sad", sad, 65025);
        check("t3_max_dev", max_dev, 255);
        check("t3_max_idx", max_idx, 0);
        check("t3_addr_err", addr_err, 0);

        // address wrap plus tie: devs 5,9,9,2
        mem_a[10'h3FE] = 8'd100; mem_b[10'h010] = 8'd105;
        mem_a[10'h3FF] = 8'd50;  mem_b[10'h011] = 8'd41;
        mem_a[10'h000] = 8'd7;   mem_b[10'h012] = 8'd16;
        mem_a[10'h001] = 8'd20;  mem_b[10'h013] = 8'd18;
        @(negedge clk);
        run_window(10'h3FE, 10'h010, 8'd4, 1'b0);
        check("t4_addr0", log_a[0], 10'h3FE);
        check("t4_addr1", log_a[1], 10'h3FF);
        check("t4_addr2", log_a[2], 10'h000);
        check("t4_addr3", log_a[3], 10'h001);
        check("t4_sad", sad, 25);
        check("t4_max_dev", max_dev, 9);
        check("t4_max_idx", max_idx, 1);

        // start re-asserted during READ must be ignored
        load_t1();
        @(negedge clk);
        run_window(10'h000, 10'h100, 8'd4, 1'b1);
        check("t5_done_cyc", done_cyc, 5);
        check("t5_sad", sad, 17);
        check("t5_max_idx", max_idx, 3);
        seen_done = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done++;
        end
        check("t5_no_extra_run", seen_done, 0);

        // reset in the middle of a len=8 window
        mem_a[0] = 8'd7;
        mem_b[10'h200] = 8'd0;
        @(negedge clk);
        start  = 1'b1;
        base_a = 10'h000;
        base_b = 10'h200;
        len    = 8'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("t6_pre_rst_sad", sad, 7);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_bram", {bus.bram_en, bus.addr_a, bus.addr_b}, 0);
        check("t6_rst_res", {sad, max_dev, max_idx}, 0);
        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        check("t6_no_done", seen_done, 0);
        load_t1();
        run_window(10'h000, 10'h100, 8'd4, 1'b0);
        check("t6_rerun_done_cyc", done_cyc, 5);
        check("t6_rerun_sad", sad, 17);
        check("t6_rerun_max", {max_dev, max_idx}, {8'd10, 8'd3});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
